life_rule_stage: RTL and testbench

Next-generation compute stage for the Game of Life pipeline. It consumes the three display row buffers (above, center, below) as a stream of one column per cycle. For each center-row cell it applies Conway's rule, with cells beyond the row edges treated as dead. It packs the results into 16-bit words and hands them, with word index, to the SDRAM write path through a valid/acknowledge handshake backed by a 2-entry FIFO.

---
 rtl/life_rule_stage_if.sv | 44 ++++
 rtl/life_rule_stage.sv | 200 ++++++++++++++++++++
 tb/tb_life_rule_stage.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/life_rule_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : life_rule_stage_if
//  Description : Bundle of the column stream and word output handshake of
//                the Game of Life next-generation stage.
//                master : upstream row-buffer reader plus downstream SDRAM
//                         write path (drives stream inputs and acknowledge)
//                slave  : the rule stage itself
//                Signals:
//                  rowStart, cellValid, cellAbove/Center/Below  stream in
//                  word, wordIndex, wordValid, wordAcknowledge  word handshake
//                  rowDone, liveCount, overflow                 row status
//  Revision    : 1.0 - initial release
// ============================================================================
interface life_rule_stage_if #(
   parameter int WORD_BITS  = 16,
   parameter int INDEX_BITS = 6
);
   logic                  rowStart;
   logic                  cellValid;
   logic                  cellAbove;
   logic                  cellCenter;
   logic                  cellBelow;
   logic [WORD_BITS-1:0]  word;
   logic [INDEX_BITS-1:0] wordIndex;
   logic                  wordValid;
   logic                  wordAcknowledge;
   logic                  rowDone;
   logic [9:0]            liveCount;
   logic                  overflow;

   modport master (
      output rowStart, cellValid, cellAbove, cellCenter, cellBelow,
      output wordAcknowledge,
      input  word, wordIndex, wordValid, rowDone, liveCount, overflow
   );

   modport slave (
      input  rowStart, cellValid, cellAbove, cellCenter, cellBelow,
      input  wordAcknowledge,
      output word, wordIndex, wordValid, rowDone, liveCount, overflow
   );
endinterface
`default_nettype wire

// File: rtl/life_rule_stage.sv
`default_nettype none
// ============================================================================
//  Module      : life_rule_stage
//  Description : Computes the next generation of one center row from a
//                column-serial stream of the rows above, center and below.
//                Results are packed into WORD_BITS-bit words and handed to
//                the SDRAM write path through a 2-entry FIFO.
//                Ports:
//                  clk  - system clock, rising edge
//                  rst  - synchronous active-high reset
//                  bus  - life_rule_stage_if.slave (stream in, words out,
//                         rowDone / liveCount / overflow status)
//  Revision    : 1.0 - initial release
// ============================================================================
module life_rule_stage #(
   parameter int COLUMNS    = 640,
   parameter int WORD_BITS  = 16,   // power of two
   parameter int INDEX_BITS = 6
) (
   input  wire logic        clk,
   input  wire logic        rst,
   life_rule_stage_if.slave bus
);
   localparam int COL_W = $clog2(COLUMNS + 1);
   localparam int BIT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] FLUSH = 2'd2;

   localparam logic [COL_W-1:0] c_last_col = COL_W'(COLUMNS - 1);
   localparam logic [BIT_W-1:0] c_last_bit = BIT_W'(WORD_BITS - 1);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [1:0]            r_state;
   logic [COL_W-1:0]      r_col;          // columns accepted in this row
   logic [2:0]            r_win_left;     // {below, center, above}
   logic [2:0]            r_win_center;   // {below, center, above}
   logic [WORD_BITS-1:0]  r_asm;
   logic [9:0]            r_live;
   logic                  r_row_done;
   logic                  r_overflow;

   logic [WORD_BITS-1:0]  r_fifo_word [2];
   logic [INDEX_BITS-1:0] r_fifo_idx  [2];
   logic                  r_rd_ptr;
   logic                  r_wr_ptr;
   logic [1:0]            r_count;

   // ---------------------------------------------------------------------
   // Combinational datapath
   // ---------------------------------------------------------------------
   logic [2:0]            w_incoming;
   logic [2:0]            w_right;
   logic                  w_accept;
   logic                  w_flush;
   logic                  w_compute;
   logic [COL_W-1:0]      w_k;
   logic [BIT_W-1:0]      w_bit;
   logic [INDEX_BITS-1:0] w_word_idx;
   logic [3:0]            w_neigh;
   logic                  w_next;
   logic [WORD_BITS-1:0]  w_asm;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_push_ok;

   always_comb begin
      w_incoming = {bus.cellBelow, bus.cellCenter, bus.cellAbove};

      // rowStart pre-empts everything: the old row is abandoned, so neither
      // an acceptance nor the flush-edge computation may happen alongside it.
      w_accept  = (r_state == RUN) && bus.cellValid && !bus.rowStart;
      w_flush   = (r_state == FLUSH) && !bus.rowStart;

      // Column 0 has no left neighbour pending, so its acceptance only
      // primes the window; every later acceptance resolves column r_col-1.
      w_compute = (w_accept && (r_col != '0)) || w_flush;

      // Beyond the last column the right neighbours are dead.
      w_right   = w_flush ? 3'b000 : w_incoming;

      // Column being resolved; in FLUSH r_col == COLUMNS so this is the last.
      w_k        = r_col - COL_W'(1);
      w_bit      = w_k[BIT_W-1:0];
      w_word_idx = INDEX_BITS'(w_k[COL_W-1:BIT_W]);

      w_neigh = 4'(r_win_left[0])   + 4'(r_win_left[1])   + 4'(r_win_left[2])
              + 4'(r_win_center[0])                       + 4'(r_win_center[2])
              + 4'(w_right[0])      + 4'(w_right[1])      + 4'(w_right[2]);

      w_next = (w_neigh == 4'd3) | (r_win_center[1] & (w_neigh == 4'd2));

      w_asm = r_asm;
      if (w_compute) begin
         w_asm[w_bit] = w_next;
      end

      w_push    = w_compute && (w_bit == c_last_bit);
      w_pop     = (r_count != 2'd0) && bus.wordAcknowledge;
      // A simultaneous pop frees the slot the push needs.
      w_push_ok = w_push && ((r_count != 2'd2) || w_pop);
   end

   // ---------------------------------------------------------------------
   // Row sequencing, window and assembly
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_col        <= '0;
         r_win_left   <= '0;
         r_win_center <= '0;
         r_asm        <= '0;
         r_live       <= '0;
         r_row_done   <= 1'b0;
      end else begin
         r_row_done <= w_flush;

         if (bus.rowStart) begin
            r_state    <= RUN;
            r_live     <= '0;
            r_asm      <= '0;
            r_win_left <= '0;
            if (bus.cellValid) begin
               // Same-cycle column is column 0 of the new row.
               r_win_center <= w_incoming;
               r_col        <= COL_W'(1);
            end else begin
               r_win_center <= '0;
               r_col        <= '0;
            end
         end else begin
            if (w_compute) begin
               r_live <= r_live + 10'(w_next);
            end

            // A completed word leaves through the FIFO, so start afresh.
            r_asm <= w_push ? '0 : w_asm;

            if (w_accept) begin
               r_win_left   <= r_win_center;
               r_win_center <= w_incoming;
               r_col        <= r_col + COL_W'(1);
               if (r_col == c_last_col) begin
                  r_state <= FLUSH;
               end
            end

            if (w_flush) begin
               r_state <= IDLE;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // 2-entry output FIFO; independent of rowStart so the previous row
   // keeps draining into the next.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fifo_word[0] <= '0;
         r_fifo_word[1] <= '0;
         r_fifo_idx[0]  <= '0;
         r_fifo_idx[1]  <= '0;
         r_rd_ptr       <= 1'b0;
         r_wr_ptr       <= 1'b0;
         r_count        <= 2'd0;
         r_overflow     <= 1'b0;
      end else begin
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         if (w_push_ok) begin
            r_fifo_word[r_wr_ptr] <= w_asm;
            r_fifo_idx[r_wr_ptr]  <= w_word_idx;
            r_wr_ptr              <= ~r_wr_ptr;
         end
         r_count <= r_count + {1'b0, w_push_ok} - {1'b0, w_pop};
         if (w_push && !w_push_ok) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs; head data reads as zero while the FIFO is empty.
   // ---------------------------------------------------------------------
   assign bus.wordValid = (r_count != 2'd0);
   assign bus.word      = (r_count != 2'd0) ? r_fifo_word[r_rd_ptr] : '0;
   assign bus.wordIndex = (r_count != 2'd0) ? r_fifo_idx[r_rd_ptr]  : '0;
   assign bus.rowDone   = r_row_done;
   assign bus.liveCount = r_live;
   assign bus.overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_life_rule_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_life_rule_stage
//  Description : Self-checking bench for life_rule_stage. A row-level model
//                evaluates Conway's rule on whole rows and predicts the word
//                stream, FIFO contents, rowDone and liveCount per cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_life_rule_stage;
   localparam int COLUMNS    = 640;
   localparam int WORD_BITS  = 16;
   localparam int INDEX_BITS = 6;
   localparam int NWORDS     = COLUMNS / WORD_BITS;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   life_rule_stage_if #(.WORD_BITS(WORD_BITS), .INDEX_BITS(INDEX_BITS)) bus ();

   life_rule_stage #(
      .COLUMNS   (COLUMNS),
      .WORD_BITS (WORD_BITS),
      .INDEX_BITS(INDEX_BITS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Rows under test and the expected next-generation center row.
   logic [COLUMNS-1:0] ra, rc, rb, rn;

   // Model state: 0 idle, 1 running, 2 last-cell pending.
   int               m_state, m_col, m_live;
   bit               m_ovf, m_rowdone;
   logic [15:0]      q_w[$];
   int               q_i[$];
   logic [15:0]      got_w[$];
   int               got_i[$];

   typedef struct {
      int          pat;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [15:0] w39;
      int          live;
   } vec_t;
   vec_t tbl[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void compute_next();
      for (int k = 0; k < COLUMNS; k++) begin
         int n = 0;
         for (int d = -1; d <= 1; d++) begin
            int j = k + d;
            if (j >= 0 && j < COLUMNS) begin
               n += int'(ra[j]) + int'(rb[j]);
               if (d != 0) n += int'(rc[j]);
            end
         end
         rn[k] = (n == 3) || (rc[k] && n == 2);
      end
   endfunction

   function automatic void set_pattern(input int pat);
      ra = '0; rc = '0; rb = '0;
      case (pat)
         0: begin ra[5] = 1; rc[5] = 1; rb[5] = 1; end
         1: begin
            ra[0] = 1; ra[1] = 1; rb[0] = 1;
            ra[638] = 1; ra[639] = 1; rb[639] = 1;
         end
         2: begin ra = '1; rc = '1; rb = '1; end
         3: begin rc[10] = 1; rc[11] = 1; rc[12] = 1; end
         4: begin ra[20] = 1; ra[21] = 1; rc[20] = 1; rc[21] = 1; end
         default: begin
            for (int i = 0; i < COLUMNS; i++) begin
               ra[i] = ($urandom_range(2) == 0);
               rc[i] = ($urandom_range(2) == 0);
               rb[i] = ($urandom_range(2) == 0);
            end
         end
      endcase
      compute_next();
   endfunction

   task automatic check_outputs();
      check("wordValid", bus.wordValid, q_w.size() > 0);
      if (q_w.size() > 0) begin
         check("word", bus.word, q_w[0]);
         check("wordIndex", bus.wordIndex, q_i[0]);
      end
      check("rowDone", bus.rowDone, m_rowdone);
      check("liveCount", bus.liveCount, m_live);
      check("overflow", bus.overflow, m_ovf);
   endtask

   // One clock: drive inputs, advance the model, then compare after the edge.
   task automatic cycle(input bit rs, input bit cv, input bit ack);
      int          dc, k, sz;
      bit          pop, push;
      logic [15:0] pw;
      dc = rs ? 0 : ((m_col < COLUMNS) ? m_col : 0);
      bus.rowStart        = rs;
      bus.cellValid       = cv;
      bus.cellAbove       = ra[dc];
      bus.cellCenter      = rc[dc];
      bus.cellBelow       = rb[dc];
      bus.wordAcknowledge = ack;
      if (ack && bus.wordValid) begin
         got_w.push_back(bus.word);
         got_i.push_back(int'(bus.wordIndex));
      end

      k = -1;
      m_rowdone = 0;
      pw = '0;
      if (rs) begin
         m_state = 1; m_live = 0; m_col = cv ? 1 : 0;
      end else if (m_state == 1 && cv) begin
         if (m_col > 0) k = m_col - 1;
         m_col++;
         if (m_col == COLUMNS) m_state = 2;
      end else if (m_state == 2) begin
         k = COLUMNS - 1; m_state = 0; m_rowdone = 1;
      end
      push = 0;
      if (k >= 0) begin
         m_live += int'(rn[k]);
         if (k % WORD_BITS == WORD_BITS - 1) begin
            push = 1;
            pw = rn[k-(WORD_BITS-1) +: WORD_BITS];
         end
      end
      sz  = q_w.size();
      pop = (sz > 0) && ack;
      if (pop) begin
         void'(q_w.pop_front());
         void'(q_i.pop_front());
      end
      if (push) begin
         if (sz < 2 || pop) begin
            q_w.push_back(pw);
            q_i.push_back(k / WORD_BITS);
         end else begin
            m_ovf = 1;
         end
      end

      @(posedge clk);
      #1;
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1;
      bus.rowStart = 0; bus.cellValid = 0; bus.wordAcknowledge = 0;
      bus.cellAbove = 0; bus.cellCenter = 0; bus.cellBelow = 0;
      @(posedge clk);
      #1;
      rst = 0;
      m_state = 0; m_col = 0; m_live = 0; m_ovf = 0; m_rowdone = 0;
      q_w.delete(); q_i.delete();
      check_outputs();
   endtask

   function automatic bit ack_bit(input int mode);
      if (mode == 2) return ($urandom_range(3) != 0);
      return (mode == 1);
   endfunction

   // Feed the rest of the current row (gap_pct % idle cycles), then drain.
   task automatic finish_row(input int gap_pct, input int ack_mode);
      int budget = 0;
      while (m_state != 0 && budget < 5000) begin
         cycle(0, ($urandom_range(99) >= gap_pct), ack_bit(ack_mode));
         budget++;
      end
      if (budget >= 5000) begin
         n_checks++; n_fail++;
         $display("FAIL row_budget: got %0d cycles, expected < 5000", budget);
      end
      repeat (4) cycle(0, 0, ack_bit(ack_mode));
   endtask

   initial begin
      tbl[0] = '{pat: 0, w0: 16'h0070, w1: 16'h0000, w39: 16'h0000, live: 3};
      tbl[1] = '{pat: 1, w0: 16'h0003, w1: 16'h0000, w39: 16'hC000, live: 4};
      tbl[2] = '{pat: 2, w0: 16'h0000, w1: 16'h0000, w39: 16'h0000, live: 0};
      tbl[3] = '{pat: 3, w0: 16'h0800, w1: 16'h0000, w39: 16'h0000, live: 1};
      tbl[4] = '{pat: 4, w0: 16'h0000, w1: 16'h0030, w39: 16'h0000, live: 2};
      ra = '0; rc = '0; rb = '0; rn = '0;

      do_reset();

      // Directed rows, acknowledge tied high.
      for (int t = 0; t < 5; t++) begin
         set_pattern(tbl[t].pat);
         got_w.delete(); got_i.delete();
         cycle(1, 0, 1);
         finish_row(0, 1);
         check("tbl_count", got_w.size(), NWORDS);
         if (got_w.size() == NWORDS) begin
            check("tbl_w0", got_w[0], tbl[t].w0);
            check("tbl_i0", got_i[0], 0);
            check("tbl_w1", got_w[1], tbl[t].w1);
            check("tbl_w39", got_w[39], tbl[t].w39);
            check("tbl_i39", got_i[39], 39);
         end
         check("tbl_live", bus.liveCount, tbl[t].live);
      end

      // Backpressure: nothing acknowledged for a whole row.
      set_pattern(0);
      cycle(1, 0, 0);
      finish_row(0, 0);
      check("bp_overflow", bus.overflow, 1);
      check("bp_valid0", bus.wordValid, 1);
      check("bp_head0", bus.word, 16'h0070);
      check("bp_idx0", bus.wordIndex, 0);
      cycle(0, 0, 1);
      check("bp_valid1", bus.wordValid, 1);
      check("bp_head1", bus.word, 16'h0000);
      check("bp_idx1", bus.wordIndex, 1);
      cycle(0, 0, 1);
      check("bp_empty", bus.wordValid, 0);

      // Reset at column 300 while overflow is still set.
      set_pattern(0);
      cycle(1, 0, 1);
      for (int c = 0; c < 300; c++) cycle(0, 1, 1);
      do_reset();
      check("rst_valid", bus.wordValid, 0);
      check("rst_overflow", bus.overflow, 0);
      check("rst_live", bus.liveCount, 0);
      got_w.delete(); got_i.delete();
      repeat (60) cycle(0, 1, 1);
      check("rst_idle_words", got_w.size(), 0);

      // rowStart with cellValid mid-row restarts at column 0.
      set_pattern(0);
      cycle(1, 0, 1);
      for (int c = 0; c < 200; c++) cycle(0, 1, 1);
      got_w.delete(); got_i.delete();
      cycle(1, 1, 1);
      finish_row(0, 1);
      check("rs_count", got_w.size(), NWORDS);
      if (got_w.size() > 0) begin
         check("rs_w0", got_w[0], 16'h0070);
         check("rs_i0", got_i[0], 0);
      end
      check("rs_live", bus.liveCount, 3);

      // Random rows with stalls and random acknowledge.
      for (int r = 0; r < 6; r++) begin
         set_pattern(99);
         cycle(1, $urandom_range(1) == 1, ack_bit(2));
         finish_row(20, 2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
